// File: rtl/key_conditioner.sv
// Multi-channel push-button front end: synchronise, debounce on a shared slow
// tick, and classify each key into level, edge, short/long-press and toggle outputs.

module key_channel #(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int CNT_W          = 12
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic tick,
    input  logic key_raw,
    input  logic toggle_en,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_short,
    output logic key_long,
    output logic key_toggle
);
    localparam int DEB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q, sync_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               level_q, level_d;
    logic               level_prev_q, level_prev_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               short_q, short_d;
    logic               long_q, long_d;
    logic               toggle_q, toggle_d;
    logic               rise, fall;

    assign rise = level_q & ~level_prev_q;
    assign fall = ~level_q & level_prev_q;

    always_comb begin
        sync_d       = {sync_q[0], key_raw};
        deb_cnt_d    = deb_cnt_q;
        level_d      = level_q;
        level_prev_d = level_q;
        press_d      = rise;
        release_d    = fall;
        short_d      = 1'b0;
        long_d       = 1'b0;
        toggle_d     = toggle_q ^ (press_q & toggle_en);
        hold_cnt_d   = hold_cnt_q;
        state_d      = state_q;

        if (tick) begin
            if (sync_q[1] != level_q) begin
                if (deb_cnt_q == DEB_W'(DEBOUNCE_TICKS - 1)) begin
                    level_d   = ~level_q;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end else begin
                deb_cnt_d = '0;
            end
        end

        // A fall is checked before the hold threshold so it wins a tie.
        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (rise) state_d = PRESSED;
            end
            PRESSED: begin
                if (fall) begin
                    short_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end else if (tick) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    if (hold_cnt_d == CNT_W'(LONG_TICKS)) begin
                        long_d  = 1'b1;
                        state_d = LONG_HELD;
                    end
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                hold_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst_n) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            deb_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            short_q      <= 1'b0;
            long_q       <= 1'b0;
            toggle_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            deb_cnt_q    <= deb_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            press_q      <= press_d;
            release_q    <= release_d;
            short_q      <= short_d;
            long_q       <= long_d;
            toggle_q     <= toggle_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_short   = short_q;
    assign key_long    = long_q;
    assign key_toggle  = toggle_q;
endmodule

module key_conditioner #(
    parameter int N_KEYS         = 4,
    parameter int CLK_HZ         = 100000000,
    parameter int TICK_HZ        = 1000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int CNT_W          = 12
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic [N_KEYS-1:0] toggle_en,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_short,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_toggle,
    output logic              tick
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_bad_div
        $error("key_conditioner: CLK_HZ/TICK_HZ must be >= 2");
    end
    if ((2 ** CNT_W) <= LONG_TICKS) begin : g_bad_cnt
        $error("key_conditioner: CNT_W too narrow for LONG_TICKS");
    end
    if (DEBOUNCE_TICKS < 1 || LONG_TICKS <= DEBOUNCE_TICKS) begin : g_bad_ticks
        $error("key_conditioner: need 1 <= DEBOUNCE_TICKS < LONG_TICKS");
    end

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

    assign tick = (div_cnt_q == DIV_W'(DIV - 1));

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (rst_n) div_cnt_q <= '0;
        else       div_cnt_q <= div_cnt_d;
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS),
            .CNT_W          (CNT_W)
        ) u_ch (
            .sys_clk     (sys_clk),
            .rst_n       (rst_n),
            .tick        (tick),
            .key_raw     (key_raw[i]),
            .toggle_en   (toggle_en[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_short   (key_short[i]),
            .key_long    (key_long[i]),
            .key_toggle  (key_toggle[i])
        );
    end
endmodule

// File: tb/tb_key_conditioner.sv
// Randomised bench for key_conditioner; expectations come from a cycle-level
// behavioural model built from press-length and tick-count arithmetic.

module tb_key_conditioner;
    localparam int NK       = 4;
    localparam int DIV      = 10;
    localparam int DEB      = 3;
    localparam int LT       = 8;
    localparam int HOLD_CYC = LT * DIV;

    logic          sys_clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_raw, toggle_en;
    logic [NK-1:0] key_level, key_press, key_release, key_short, key_long, key_toggle;
    logic          tick;

    always #5 sys_clk = ~sys_clk;

    key_conditioner #(
        .N_KEYS(NK), .CLK_HZ(1000), .TICK_HZ(100),
        .DEBOUNCE_TICKS(DEB), .LONG_TICKS(LT), .CNT_W(4)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .key_raw     (key_raw),
        .toggle_en   (toggle_en),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_short   (key_short),
        .key_long    (key_long),
        .key_toggle  (key_toggle),
        .tick        (tick)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model state: cycles since reset, raw samples still in flight through the
    // synchroniser, debounced level history and how long each key has been held.
    int            m_cyc;
    logic [NK-1:0] m_hist[$];
    logic [NK-1:0] m_lvl, m_lvl_d1, m_lvl_d2, m_tog;
    int            m_run[NK], m_hi[NK], m_hi_d1[NK], m_hi_d2[NK];
    bit            chk_en = 1'b0;

    function automatic void m_reset();
        m_cyc    = 0;
        m_hist   = {NK'(0), NK'(0)};
        m_lvl    = '0;
        m_lvl_d1 = '0;
        m_lvl_d2 = '0;
        m_tog    = '0;
        for (int i = 0; i < NK; i++) begin
            m_run[i] = 0; m_hi[i] = 0; m_hi_d1[i] = 0; m_hi_d2[i] = 0;
        end
    endfunction

    task automatic step();
        logic [NK-1:0] e_press, e_rel, e_short, e_long, sync, nxt;
        bit tk;
        @(negedge sys_clk);
        tk = (m_cyc % DIV) == DIV - 1;
        for (int i = 0; i < NK; i++) begin
            e_press[i] = m_lvl_d1[i] & ~m_lvl_d2[i];
            e_rel[i]   = ~m_lvl_d1[i] & m_lvl_d2[i];
            e_short[i] = e_rel[i] && (m_hi_d2[i] < HOLD_CYC);
            e_long[i]  = (m_hi_d1[i] == HOLD_CYC);
        end
        if (chk_en) begin
            chk("tick",    32'(tick),        32'(tk));
            chk("level",   32'(key_level),   32'(m_lvl));
            chk("press",   32'(key_press),   32'(e_press));
            chk("release", 32'(key_release), 32'(e_rel));
            chk("short",   32'(key_short),   32'(e_short));
            chk("long",    32'(key_long),    32'(e_long));
            chk("toggle",  32'(key_toggle),  32'(m_tog));
        end
        if (rst_n) begin
            m_reset();
            chk_en = 1'b1;
        end else begin
            m_tog = m_tog ^ (e_press & toggle_en);
            sync  = m_hist[0];
            nxt   = m_lvl;
            if (tk) begin
                for (int i = 0; i < NK; i++) begin
                    if (sync[i] != m_lvl[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DEB) begin
                            nxt[i]   = ~nxt[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            for (int i = 0; i < NK; i++) begin
                m_hi_d2[i] = m_hi_d1[i];
                m_hi_d1[i] = m_hi[i];
                m_hi[i]    = nxt[i] ? m_hi[i] + 1 : 0;
            end
            m_lvl_d2 = m_lvl_d1;
            m_lvl_d1 = m_lvl;
            m_lvl    = nxt;
            void'(m_hist.pop_front());
            m_hist.push_back(key_raw);
            m_cyc++;
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        int rate;
        m_reset();
        rst_n     = 1'b1;
        key_raw   = '0;
        toggle_en = '0;
        run(3);
        rst_n = 1'b0;

        // single key acceptance
        key_raw[0] = 1'b1;
        run(60);

        // sub-debounce glitch on key 1
        key_raw[1] = 1'b1;
        run($urandom_range(5, 20));
        key_raw[1] = 1'b0;
        run(40);

        // short press on key 2
        key_raw[2] = 1'b1;
        run(30 + 5 * DIV + $urandom_range(0, 9));
        key_raw[2] = 1'b0;
        run(60);

        // long press on key 3
        key_raw[3] = 1'b1;
        run(30 + 20 * DIV);
        key_raw[3] = 1'b0;
        run(60);

        // toggle only armed on key 0
        toggle_en  = 4'b0001;
        key_raw[0] = 1'b0;
        run(60);
        repeat (3) begin
            key_raw[0] = 1'b1;
            run(50);
            key_raw[0] = 1'b0;
            run(50);
        end
        key_raw[1] = 1'b1;
        run(50);
        key_raw[1] = 1'b0;
        run(50);

        // reset while key 0 is in long hold, raw kept pressed
        key_raw[0] = 1'b1;
        run(40 + HOLD_CYC + 20);
        rst_n = 1'b1;
        run(1);
        rst_n = 1'b0;
        run(40 + HOLD_CYC + 30);
        key_raw[0] = 1'b0;
        run(60);

        // random segments with mixed bounce rates and occasional resets
        for (int seg = 0; seg < 6; seg++) begin
            case ($urandom_range(0, 2))
                0:       rate = 8;
                1:       rate = 30;
                default: rate = 120;
            endcase
            repeat (500) begin
                for (int i = 0; i < NK; i++)
                    if ($urandom_range(0, rate - 1) == 0) key_raw[i] = ~key_raw[i];
                if ($urandom_range(0, 99) == 0) toggle_en = NK'($urandom);
                rst_n = ($urandom_range(0, 999) == 0);
                step();
            end
        end
        rst_n = 1'b0;
        run(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
Parametrised multi-channel push-button front end that replaces single-button debounce-plus-hold logic.
Each of N_KEYS raw inputs is synchronised, debounced on a shared slow tick, and classified per channel into the following outputs:
- debounced level;
- press, release, short-press and long-press pulses;
- an optional toggle latch.

It sits between board buttons and the car control FSMs (power on/off, mode select, turn signals). All outputs are in the sys_clk domain.

Parameters:
N_KEYS, 4, number of independent key channels
CLK_HZ, 100000000, sys_clk frequency
TICK_HZ, 1000, debounce/hold sampling rate; DIV = CLK_HZ/TICK_HZ, must be >= 2
DEBOUNCE_TICKS, 20, consecutive differing ticks needed to accept a level change (>= 1)
LONG_TICKS, 1000, ticks a key must stay debounced-high before key_long fires (> DEBOUNCE_TICKS)
CNT_W, 12, width of per-channel hold counter; must satisfy 2^CNT_W > LONG_TICKS (elaboration check)

Ports:
sys_clk  input  1  system clock
rst_n  input  1  synchronous reset, active-high (1 = reset), sampled on rising sys_clk
key_raw  input  N_KEYS  asynchronous raw button levels, 1 = pressed
toggle_en  input  N_KEYS  per-channel enable of toggle latch
key_level  output  N_KEYS  debounced level
key_press  output  N_KEYS  1-cycle pulse on debounced 0->1
key_release  output  N_KEYS  1-cycle pulse on debounced 1->0
key_short  output  N_KEYS  1-cycle pulse on release before long threshold
key_long  output  N_KEYS  1-cycle pulse when hold reaches LONG_TICKS, once per press
key_toggle  output  N_KEYS  flips on each key_press while toggle_en[i]=1
tick  output  1  1-cycle pulse every DIV sys_clk cycles (exported for other slow logic)

Behaviour:
Reset:
- All outputs are 0.
- The tick divider, synchroniser flops, debounce counters and hold counters clear to 0.
- Every channel FSM goes to IDLE.

Tick divider:
- div_cnt counts 0..DIV-1 and wraps.
- tick=1 for exactly the cycle where div_cnt==DIV-1.
- The first tick after reset release occurs DIV cycles later.

Synchroniser:
- Each key passes through a 2-flop synchroniser, giving key_sync.

Debounce (per channel, evaluated only on tick cycles):
- If key_sync != key_level, deb_cnt increments.
- When deb_cnt == DEBOUNCE_TICKS-1 on a tick, key_level is inverted on that clock edge and deb_cnt clears to 0.
- If key_sync == key_level on a tick, deb_cnt clears to 0, so glitches shorter than DEBOUNCE_TICKS ticks are rejected.
- Latency from a stable raw change to key_level change: between (DEBOUNCE_TICKS-1)*DIV+3 and DEBOUNCE_TICKS*DIV+2 sys_clk cycles.

Event pulses:
- key_press[i] and key_release[i] assert the cycle after key_level[i] changes, for exactly 1 cycle.

Channel FSM (per channel):
- IDLE: hold_cnt=0. On debounced rise, go to PRESSED.
- PRESSED:
  - hold_cnt increments on each tick.
  - When hold_cnt reaches LONG_TICKS, pulse key_long and go to LONG_HELD.
  - On debounced fall, pulse key_short and go to IDLE.
- LONG_HELD:
  - hold_cnt is frozen, so it never wraps.
  - On debounced fall, return to IDLE with no key_short; key_release still pulses.
- If the fall and the LONG_TICKS tick land in the same cycle, the fall wins: key_short pulses and key_long does not.

Toggle:
- key_toggle[i] inverts on the cycle key_press[i] pulses, only if toggle_en[i]=1 in that cycle.
- toggle_en[i]=0 holds the current value; it does not clear it.

Channel independence:
- Channels are fully independent.
- Simultaneous events on several channels each produce their own pulses in the same cycle.

Reset mid-operation:
- Reset while a key is held drops key_level to 0 and discards the hold.
- If the raw key is still held after reset, a fresh debounce yields a new key_press.
- key_long then needs a full LONG_TICKS again.

Test Plan:
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), DEBOUNCE_TICKS=3, LONG_TICKS=8, N_KEYS=4, CNT_W=4.
1. Reset, then key_raw[0] 0->1 held -> key_level[0]=1 within 23..32 cycles; key_press[0] 1-cycle pulse; other channels stay 0; tick every 10 cycles.
2. key_raw[1] glitch high for 2 ticks (20 cycles), then low -> key_level[1], key_press[1] and key_release[1] stay 0 throughout.
3. key_raw[2] held 5 ticks past acceptance, then released -> key_press[2], then key_release[2] and key_short[2] in the same cycle; key_long[2] never asserts.
4. key_raw[3] held 20 ticks past acceptance -> exactly one key_long[3] pulse, 8 ticks after key_level rises; on release, key_release[3]=1 and key_short[3]=0.
5. toggle_en=4'b0001, three debounced presses on key 0 and one on key 1 -> key_toggle[0] goes 1,0,1; key_toggle[1] stays 0.
6. Key 0 held in LONG_HELD, assert rst_n=1 for 1 cycle -> all outputs 0 next cycle; with raw still 1, a new key_press[0] occurs after a fresh debounce and key_long[0] fires 8 ticks after that.
